// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Latched data-memory bus payload, held stable for the whole BUSY phase.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } dmem_bus_t;

  // Halves must be 2-byte aligned, words 4-byte aligned; size 11 is illegal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Extracts a byte/half/word from a read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        is_signed_i,
  output logic [31:0] data_c_o
);

  logic [15:0] low_c;

  always_comb begin
    low_c    = 16'(rdata_i >> {off_i, 3'b000});
    data_c_o = rdata_i;
    case (size_i)
      SZ_B:    data_c_o = {{24{is_signed_i & low_c[7]}}, low_c[7:0]};
      SZ_H:    data_c_o = {{16{is_signed_i & low_c[15]}}, low_c[15:0]};
      default: data_c_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request/ack bus transaction per access,
// stalling the core until it completes or times out.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [2:0]  i_funct3,
  input  logic        i_isLoadSigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_storeData,
  output logic        o_stall,
  output logic [31:0] o_loadData,
  output logic        o_loadValid,
  output logic        o_misaligned,
  output logic        o_busError,
  output logic        o_dmemReq,
  output logic        o_dmemWrite,
  output logic [31:0] o_dmemAddr,
  output logic [31:0] o_dmemWdata,
  output logic [3:0]  o_dmemByteEn,
  input  logic        i_dmemAck,
  input  logic [31:0] i_dmemRdata
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  lsu_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]     off_q, off_d;
  logic [1:0]     size_q, size_d;
  logic           signed_q, signed_d;
  logic           req_q, req_d;
  dmem_bus_t      bus_q, bus_d;
  logic [31:0]    load_data_q, load_data_d;
  logic           load_valid_q, load_valid_d;
  logic           bus_err_q, bus_err_d;

  logic [1:0]     size_c;
  logic           mis_c;
  logic           accept_c;
  logic [31:0]    aligned_c;
  logic           unused_funct3_c;

  assign unused_funct3_c = i_funct3[2];
  assign size_c   = i_funct3[1:0];
  assign mis_c    = is_misaligned(size_c, i_addr[1:0]);
  assign accept_c = (state_q == ST_IDLE) & i_memReq & ~mis_c;

  load_align u_load_align (
    .rdata_i     (i_dmemRdata),
    .off_i       (off_q),
    .size_i      (size_q),
    .is_signed_i (signed_q),
    .data_c_o    (aligned_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      req_q        <= 1'b0;
      bus_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      req_q        <= req_d;
      bus_q        <= bus_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Next-state: accept in IDLE, wait for ack or timeout in BUSY, one-cycle DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    req_d        = req_q;
    bus_d        = bus_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d      = ST_BUSY;
          cnt_d        = '0;
          off_d        = i_addr[1:0];
          size_d       = size_c;
          signed_d     = i_isLoadSigned;
          req_d        = 1'b1;
          bus_d        = '0;
          bus_d.write  = i_memWrite;
          bus_d.addr   = {i_addr[31:2], 2'b00};
          if (i_memWrite) begin
            case (size_c)
              SZ_B: begin
                bus_d.wdata   = {4{i_storeData[7:0]}};
                bus_d.byte_en = 4'b0001 << i_addr[1:0];
              end
              SZ_H: begin
                bus_d.wdata   = {2{i_storeData[15:0]}};
                bus_d.byte_en = 4'b0011 << i_addr[1:0];
              end
              default: begin
                bus_d.wdata   = i_storeData;
                bus_d.byte_en = 4'b1111;
              end
            endcase
          end
        end
      end
      ST_BUSY: begin
        // An ack on the final wait cycle still completes normally.
        if (i_dmemAck) begin
          if (!bus_q.write) begin
            load_data_d  = aligned_c;
            load_valid_d = 1'b1;
          end
          state_d = ST_DONE;
          cnt_d   = '0;
          req_d   = 1'b0;
          bus_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
          cnt_d     = '0;
          req_d     = 1'b0;
          bus_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall and misalign flags are combinational; reset forces them low too.
  assign o_stall      = i_rst_n & (accept_c | (state_q == ST_BUSY));
  assign o_misaligned = i_rst_n & (state_q == ST_IDLE) & i_memReq & mis_c;

  assign o_loadData   = load_data_q;
  assign o_loadValid  = load_valid_q;
  assign o_busError   = bus_err_q;
  assign o_dmemReq    = req_q;
  assign o_dmemWrite  = bus_q.write;
  assign o_dmemAddr   = bus_q.addr;
  assign o_dmemWdata  = bus_q.wdata;
  assign o_dmemByteEn = bus_q.byte_en;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the RV32I core. It sits directly downstream of the main decoder and ALU. It consumes the decoder's memory request, memory write, funct3 and load-signedness controls, together with the ALU-computed address and the rs2 store data. It runs a request/acknowledge transaction on the data-memory bus, stalls the core until the access completes, and returns aligned, sign- or zero-extended load data to the writeback mux.

## Interface
- `MAX_WAIT`, default 15: cycles to wait for `i_dmemAck` before aborting with a bus error (must be ≥1).
- `i_clk`  in  1  core clock; all state changes on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_memReq`  in  1  decoder: instruction accesses data memory.
- `i_memWrite`  in  1  decoder: 1 = store, 0 = load.
- `i_funct3`  in  3  access size in [1:0] (00 byte, 01 half, 10 word); [2] is unused here.
- `i_isLoadSigned`  in  1  decoder: 1 = LB/LH sign-extend, 0 = LBU/LHU zero-extend.
- `i_addr`  in  32  ALU result (byte address).
- `i_storeData`  in  32  rs2 value.
- `o_stall`  out  1  hold PC and pipeline registers.
- `o_loadData`  out  32  extended load result, valid when `o_loadValid`.
- `o_loadValid`  out  1  one-cycle pulse, load completed.
- `o_misaligned`  out  1  access is misaligned or has an illegal size (combinational, IDLE only).
- `o_busError`  out  1  one-cycle pulse, transaction timed out.
- `o_dmemReq`  out  1  bus request, held until acknowledged.
- `o_dmemWrite`  out  1  bus write.
- `o_dmemAddr`  out  32  word address, {addr[31:2], 2'b00}.
- `o_dmemWdata`  out  32  lane-replicated store data.
- `o_dmemByteEn`  out  4  byte lanes written (0000 on loads).
- `i_dmemAck`  in  1  bus completes the access this cycle.
- `i_dmemRdata`  in  32  read word, valid with `i_dmemAck`.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - Misalignment: size 01 with addr[0]=1, size 10 with addr[1:0]≠00, or size 11.
  - If `i_memReq` and not misaligned: latch address, size, signedness, write flag, lane data and byte enables, then go to BUSY.
  - If `i_memReq` and misaligned: `o_misaligned`=1, no bus activity, no stall, stay in IDLE.
- **BUSY**
  - `o_dmemReq`=1 and all bus outputs are driven from the latched registers.
  - Wait counter increments each cycle without `i_dmemAck`.
  - On `i_dmemAck`: register the extended `i_dmemRdata` into `o_loadData` for loads, clear the counter, go to DONE.
  - If the counter reaches `MAX_WAIT` without an ack: abort, set the error flag, go to DONE.
- **DONE**
  - `o_stall`=0; the core advances this cycle.
  - `o_loadValid`=1 for a completed load; `o_busError`=1 if the transaction aborted.
  - `i_memReq` is ignored here because it still belongs to the finishing instruction.
  - Always returns to IDLE.
- `o_stall` = (IDLE ∧ `i_memReq` ∧ ¬misaligned) ∨ BUSY.
- Store lanes, with k = addr[1:0]:
  - SB: data {4{rs2[7:0]}}, byte enables 0001<<k.
  - SH: data {2{rs2[15:0]}}, byte enables 0011<<k.
  - SW: data rs2, byte enables 1111.
- Load extract:
  - Shift the read word right by 8·k.
  - Take bits [7:0] or [15:0] and extend with bit 7 or bit 15 when signed, with zeros when unsigned.
  - Word loads pass the read word through; signedness is irrelevant.
- A store completes with `o_loadValid`=0; `o_loadData` holds its previous value.
- An ack arriving in IDLE or DONE is ignored.
- An ack in the same cycle the counter would expire wins: the transaction completes normally.

## Timing
- Reset (asynchronous, immediate): state IDLE; all outputs and registers 0. An in-flight `o_dmemReq` drops at once, and the bus must tolerate the abandoned request.
- Zero-wait memory (ack in the first BUSY cycle): accept at c0, BUSY at c1, DONE at c2. `o_stall` is high c0–c1 and low at c2.
- Ack after n wait cycles: stall lasts 2+n cycles.
- Timeout: stall lasts 1+`MAX_WAIT` cycles, then `o_busError` pulses in DONE.
- Back-to-back memory instructions: the next one is accepted in the IDLE cycle after DONE, so every access costs at least 3 cycles.
- Bus outputs are registered and stable throughout BUSY; they are 0 outside BUSY.

## Structure
- Package `lsu_pkg`:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
- Sub-module `load_align`: combinational extract plus sign/zero extension (inputs: read word, offset, size, signed). It is shared with any future cache refill path.

## Test plan
- **LW, zero-wait:** LW addr 0x104, rdata 0xDEADBEEF, ack in the first BUSY cycle → `o_dmemAddr`=0x104, stall 2 cycles, `o_loadData`=0xDEADBEEF with `o_loadValid` in the 3rd cycle.
- **LB / LBU:** addr 0x103, rdata 0x80FFFFFF → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **SH:** addr 0x202, rs2 0x1234ABCD → byte enables 1100, wdata 0xABCDABCD, `o_dmemWrite`=1, `o_loadValid` stays 0.
- **Misaligned LW:** LW addr 0x101 → `o_misaligned`=1, `o_dmemReq` never asserted, `o_stall`=0.
- **Wait states and timeout:**
  - Ack after 3 wait cycles → stall 5 cycles.
  - No ack with `MAX_WAIT`=4 → `o_busError` pulses after stall of 5, FSM back in IDLE.
- **Reset mid-transaction:** assert `i_rst_n`=0 mid-BUSY → `o_dmemReq`, `o_stall` and all outputs drop to 0 immediately. After release, a fresh LW completes normally.
